// File: rtl/rr_request_arbiter.sv
// rr_request_arbiter: round-robin arbiter with a registered one-hot grant that feeds an 8-to-3 encoder.
// Optional macro ARB_TIMEOUT_EN forces a handoff once an owner has held the grant for MAX_HOLD cycles.
module rr_request_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic [2:0]   owner_idx
);

  // The grant drives an 8-bit encoder input, so no other width is meaningful.
  if (N != 8) begin : g_bad_n
    $error("rr_request_arbiter: N must be 8");
  end

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_hold
    $error("rr_request_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set bit of v at or after start, wrapping; result is {found, index}.
  function automatic logic [3:0] search(input logic [N-1:0] v, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] k;
    res = 4'b0000;
    for (int i = N - 1; i >= 0; i--) begin
      k = start + 3'(i);
      if (v[k]) begin
        res = {1'b1, k};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [2:0] idx);
    logic [N-1:0] v;
    v = {{(N-1){1'b0}}, 1'b1};
    return v << idx;
  endfunction

  state_t       state_r;
  logic [2:0]   ptr_r;
  logic [7:0]   hold_r;

  logic [2:0]   next_ptr_s;
  logic [N-1:0] others_s;
  logic [3:0]   idle_pick_s;
  logic [3:0]   hand_pick_s;
  logic         release_s;
  logic         timeout_s;

  // Candidate winners for a fresh arbitration and for a handoff away from the owner.
  always_comb begin
    next_ptr_s  = owner_idx + 3'd1;
    others_s    = req & ~grant;
    idle_pick_s = search(req, ptr_r);
    hand_pick_s = search(others_s, next_ptr_s);
    release_s   = ~req[owner_idx];
`ifdef ARB_TIMEOUT_EN
    timeout_s   = req[owner_idx] && (hold_r == 8'(MAX_HOLD));
`else
    timeout_s   = 1'b0;
`endif
  end

  // Arbitration FSM; grant, grant_valid and owner_idx are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= 3'd0;
      hold_r      <= 8'd0;
      grant       <= {N{1'b0}};
      grant_valid <= 1'b0;
      owner_idx   <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (idle_pick_s[3]) begin
            state_r     <= GRANT;
            grant       <= onehot(idle_pick_s[2:0]);
            grant_valid <= 1'b1;
            owner_idx   <= idle_pick_s[2:0];
            hold_r      <= 8'd1;
          end else begin
            state_r     <= IDLE;
          end
        end
        GRANT: begin
          if (release_s || timeout_s) begin
            // Priority moves past the outgoing owner whether or not anyone takes over.
            ptr_r <= next_ptr_s;
            if (hand_pick_s[3]) begin
              grant     <= onehot(hand_pick_s[2:0]);
              owner_idx <= hand_pick_s[2:0];
              hold_r    <= 8'd1;
            end else if (timeout_s) begin
              hold_r    <= 8'd1;
            end else begin
              state_r     <= IDLE;
              grant       <= {N{1'b0}};
              grant_valid <= 1'b0;
              owner_idx   <= 3'd0;
              hold_r      <= 8'd0;
            end
          end else if (hold_r != 8'hFF) begin
            hold_r <= hold_r + 8'd1;
          end else begin
            hold_r <= hold_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          grant       <= {N{1'b0}};
          grant_valid <= 1'b0;
          owner_idx   <= 3'd0;
          hold_r      <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_request_arbiter.md
Name: rr_request_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 8-to-3 encoder.
- Takes N independent request lines and produces a registered one-hot grant vector; that vector drives the encoder's 8-bit input, so it is only ever one-hot or all-zero.
- Ownership is held while the owner keeps requesting. Priority rotates past the last owner so every requester gets fair access.

Parameters:
- N, 8, number of requesters. The only supported value is 8, to match the encoder width; elaboration must fail for any other value.
- MAX_HOLD, 15, maximum consecutive cycles one owner may hold the grant. Used only when ARB_TIMEOUT_EN is defined. Range 2..255.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset, synchronous, active-high
- req  input  N  request lines, bit k = requester k, level-sensitive
- grant  output  N  registered one-hot grant, or all-zero when no owner; feeds the encoder input
- grant_valid  output  1  1 when grant is non-zero
- owner_idx  output  3  binary index of the current owner; 0 when grant_valid=0

Behaviour:
- Reset (rst=1 sampled at a rising edge):
  - grant=0, grant_valid=0, owner_idx=0.
  - Rotation pointer ptr=0, so bit 0 has highest priority.
  - State=IDLE; hold counter=0.
  - rst has priority over all other inputs. A reset in the middle of a grant clears the grant at that same edge.
- Outputs are registered. No combinational path from req to grant.
- Search function: search(v, start) returns the first set bit of v scanning start, start+1, ..., N-1, 0, ..., start-1 (mod N), or none.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0 at an edge: grant <= onehot(search(req, ptr)), state -> GRANT, hold counter -> 1.
  - Otherwise stay in IDLE.
  - Latency: request sampled at edge k, grant visible after edge k (one cycle).
- GRANT, owner o:
  - req[o]=1: keep the grant; hold counter increments and saturates at 255.
  - req[o]=0 at an edge (release):
    - ptr <= (o+1) mod N.
    - w = search(req with bit o masked, (o+1) mod N).
    - If w exists: grant <= onehot(w) at the same edge (zero-bubble handoff), hold counter -> 1, stay in GRANT.
    - If no w: grant <= 0, state -> IDLE.
- Other requesters' req bits are ignored for preemption. A non-owner rising or falling mid-grant has no effect until the next arbitration.
- Simultaneous requests in IDLE resolve by ptr order only.
- ptr updates only on release or timeout, never while IDLE.
- Invariants (checked by the bench every cycle):
  - popcount(grant) <= 1.
  - grant_valid == (grant != 0).
  - owner_idx equals the set bit position.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined, GRANT with owner o:
  - When the hold counter equals MAX_HOLD and req[o] is still 1, a forced handoff occurs at that edge, using the same rules as release (ptr <= o+1, search with o masked).
  - If no other requester exists, o keeps the grant and the hold counter restarts at 1.
  - Net effect: no owner holds the grant for more than MAX_HOLD consecutive cycles while others wait.
- Not defined:
  - No timeout logic and no counter compare.
  - An owner holds the grant indefinitely while req[o]=1.
  - The hold counter may be removed by synthesis.

Test Plan:
- Reset, then req=8'b0000_0001 for 3 cycles then 0 -> grant=8'h01 one cycle after req, held 3 cycles, then 8'h00 one cycle after req drops; owner_idx=0; ptr now 1.
- From reset, req=8'b1000_0001 held -> grant=8'h01. Drop bit0 -> grant=8'h80 at the same edge with no bubble, owner_idx=7. Drop bit7 -> grant=0, IDLE.
- Sweep walking one-hot req 8'h01, 8'h02, ..., 8'h80, each held 2 cycles, with 1 idle cycle between -> grant equals req each time, delayed one cycle; owner_idx steps 0..7.
- req=8'hFF constant, each owner deasserts for one cycle when granted, then reasserts -> grant order 8'h01, 02, 04, ..., 80, 01 (wrap); no index granted twice within 8 consecutive grants.
- rst=1 asserted mid-grant (owner 5, req=8'h20) -> grant=0 and owner_idx=0 at that edge. After rst=0 with req=8'h21 -> grant=8'h01, showing ptr reset to 0.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h03 constant -> grant 8'h01 for 4 cycles, 8'h02 for 4 cycles, then 8'h01 again. With req=8'h01 only -> grant stays 8'h01 continuously.
